idma_dp_scheduler: RTL



---
 rtl/idma_dp_scheduler.sv | 183 ++++++++++++++++++
 1 files changed

// File: rtl/idma_dp_scheduler.sv
// idma_dp_scheduler: turns legalized bursts into read/write datapath requests.
// Each side has a single request register and drains on its own. Bursts in
// flight are credit-limited and retire when the write datapath responds.
module idma_dp_scheduler #(
    parameter int unsigned StrbWidth     = 2,
    parameter int unsigned AddrWidth     = 32,
    parameter int unsigned LenWidth      = 32,
    parameter int unsigned NumAxInFlight = 2,
    localparam int unsigned OffW         = $clog2(StrbWidth),
    localparam int unsigned CntW         = $clog2(NumAxInFlight + 1)
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic [AddrWidth-1:0] burst_src_addr_i,
    input  logic [AddrWidth-1:0] burst_dst_addr_i,
    input  logic [LenWidth-1:0]  burst_len_i,
    input  logic                 burst_valid_i,
    output logic                 burst_ready_o,
    output logic [OffW-1:0]      r_offset_o,
    output logic [OffW-1:0]      r_tailer_o,
    output logic [OffW-1:0]      r_shift_o,
    output logic [LenWidth-1:0]  r_beats_o,
    output logic                 r_valid_o,
    input  logic                 r_ready_i,
    output logic [OffW-1:0]      w_offset_o,
    output logic [OffW-1:0]      w_tailer_o,
    output logic [OffW-1:0]      w_shift_o,
    output logic [LenWidth-1:0]  w_beats_o,
    output logic                 w_valid_o,
    input  logic                 w_ready_i,
    input  logic                 w_rsp_valid_i,
    input  logic                 w_rsp_error_i,
    output logic                 w_rsp_ready_o,
    output logic                 burst_done_o,
    output logic                 burst_error_o,
    output logic [CntW-1:0]      outstanding_o
    ,
    output logic                 busy_o
);

    localparam logic [CntW-1:0] MaxCnt = CntW'(NumAxInFlight);

    logic [OffW-1:0]     src_off, dst_off, r_end, w_end;
    logic [LenWidth:0]   r_sum, w_sum;
    logic [OffW-1:0]     r_tail, w_tail, w_shft;
    logic [LenWidth-1:0] r_nbeats, w_nbeats;

    logic r_free, w_free, w_rsp_fire, accept, len_zero, load, drop;

    logic                r_valid_q, w_valid_q;
    logic [OffW-1:0]     r_offset_q, r_tailer_q, r_shift_q;
    logic [OffW-1:0]     w_offset_q, w_tailer_q, w_shift_q;
    logic [LenWidth-1:0] r_beats_q, w_beats_q;
    logic [CntW-1:0]     cnt_q, cnt_d;
    logic                done_q, done_d, err_q, err_d, pend_q, pend_d;

    logic unused_addr;
    assign unused_addr = ^{burst_src_addr_i[AddrWidth-1:OffW],
                           burst_dst_addr_i[AddrWidth-1:OffW]};

    // Request fields; only the low address bits matter, sums carry one spare bit.
    always_comb begin
        src_off  = burst_src_addr_i[OffW-1:0];
        dst_off  = burst_dst_addr_i[OffW-1:0];
        r_end    = src_off + burst_len_i[OffW-1:0];
        w_end    = dst_off + burst_len_i[OffW-1:0];
        r_tail   = '0 - r_end;
        w_tail   = '0 - w_end;
        w_shft   = '0 - dst_off;
        r_sum    = (LenWidth+1)'(src_off) + {1'b0, burst_len_i} - (LenWidth+1)'(1);
        w_sum    = (LenWidth+1)'(dst_off) + {1'b0, burst_len_i} - (LenWidth+1)'(1);
        r_nbeats = LenWidth'(r_sum >> OffW);
        w_nbeats = LenWidth'(w_sum >> OffW);
    end

    assign r_free        = ~r_valid_q | r_ready_i;
    assign w_free        = ~w_valid_q | w_ready_i;
    assign w_rsp_ready_o = (cnt_q != '0);
    assign w_rsp_fire    = w_rsp_valid_i & w_rsp_ready_o;
    // A deferred zero-length done pulse blocks intake so at most one can be pending.
    assign burst_ready_o = r_free & w_free & ((cnt_q < MaxCnt) | w_rsp_fire) & ~pend_q;
    assign accept        = burst_valid_i & burst_ready_o;
    assign len_zero      = (burst_len_i == '0);
    assign load          = accept & ~len_zero;
    assign drop          = accept & len_zero;

    // Credit count and done-pulse arbitration; a response beats a drop or a pending drop.
    always_comb begin
        cnt_d  = cnt_q;
        done_d = 1'b0;
        err_d  = 1'b0;
        pend_d = 1'b0;
        if (load && !w_rsp_fire) begin
            cnt_d = cnt_q + CntW'(1);
        end else if (!load && w_rsp_fire) begin
            cnt_d = cnt_q - CntW'(1);
        end
        if (w_rsp_fire) begin
            done_d = 1'b1;
            err_d  = w_rsp_error_i;
            pend_d = pend_q | drop;
        end else if (pend_q || drop) begin
            done_d = 1'b1;
        end
    end

    // Read request register: load on accept, clear on handshake.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_valid_q  <= 1'b0;
            r_offset_q <= '0;
            r_tailer_q <= '0;
            r_shift_q  <= '0;
            r_beats_q  <= '0;
        end else if (load) begin
            r_valid_q  <= 1'b1;
            r_offset_q <= src_off;
            r_tailer_q <= r_tail;
            r_shift_q  <= src_off;
            r_beats_q  <= r_nbeats;
        end else if (r_ready_i) begin
            r_valid_q  <= 1'b0;
        end
    end

    // Write request register: load on accept, clear on handshake.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            w_valid_q  <= 1'b0;
            w_offset_q <= '0;
            w_tailer_q <= '0;
            w_shift_q  <= '0;
            w_beats_q  <= '0;
        end else if (load) begin
            w_valid_q  <= 1'b1;
            w_offset_q <= dst_off;
            w_tailer_q <= w_tail;
            w_shift_q  <= w_shft;
            w_beats_q  <= w_nbeats;
        end else if (w_ready_i) begin
            w_valid_q  <= 1'b0;
        end
    end

    // Outstanding counter and completion flags.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q  <= '0;
            done_q <= 1'b0;
            err_q  <= 1'b0;
            pend_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            done_q <= done_d;
            err_q  <= err_d;
            pend_q <= pend_d;
        end
    end

    assign r_offset_o    = r_offset_q;
    assign r_tailer_o    = r_tailer_q;
    assign r_shift_o     = r_shift_q;
    assign r_beats_o     = r_beats_q;
    assign r_valid_o     = r_valid_q;
    assign w_offset_o    = w_offset_q;
    assign w_tailer_o    = w_tailer_q;
    assign w_shift_o     = w_shift_q;
    assign w_beats_o     = w_beats_q;
    assign w_valid_o     = w_valid_q;
    assign burst_done_o  = done_q;
    assign burst_error_o = err_q;
    assign outstanding_o = cnt_q;
    assign busy_o        = (cnt_q != '0) | r_valid_q | w_valid_q;

    // A response arriving with nothing in flight must never be accepted.
    a_no_rsp_when_empty: assert property (@(posedge clk_i) disable iff (!rst_ni)
        !(w_rsp_valid_i && cnt_q == '0 && w_rsp_ready_o));

    // The credit counter never exceeds its limit.
    a_cnt_in_range: assert property (@(posedge clk_i) disable iff (!rst_ni)
        cnt_q <= MaxCnt);

endmodule
